// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle controller: states, opcodes, funct and ALU codes.
// Pure definitions; no logic, no latency, no flow control.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_READ2,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [2:0] FN_ADD = 3'd0;
    localparam logic [2:0] FN_SUB = 3'd1;
    localparam logic [2:0] FN_AND = 3'd2;
    localparam logic [2:0] FN_OR  = 3'd3;
    localparam logic [2:0] FN_SLT = 3'd4;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic [3:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [2:0] funct;
    } instr_t;

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the controller (master) and datapath plus memory (slave).
// Wires only; memory handshake is mem_rd/mem_wr request with mem_ready completion.
interface multicycle_ctrl_if;
    logic [15:0] instr;
    logic        zero;
    logic        mem_ready;
    logic [2:0]  ALUCtrl;
    logic        selMux1;
    logic [2:0]  reg_sel;
    logic        rd1;
    logic        rd2;
    logic        wr;
    logic        mem_to_reg;
    logic        mem_rd;
    logic        mem_wr;
    logic        ir_wr;
    logic        pc_wr;
    logic        pc_src;
    logic [15:0] imm;
    logic        halted;
    logic        fault;
    logic        illegal;
    logic [15:0] retired;

    modport master (
        input  instr, zero, mem_ready,
        output ALUCtrl, selMux1, reg_sel, rd1, rd2, wr, mem_to_reg,
               mem_rd, mem_wr, ir_wr, pc_wr, pc_src, imm,
               halted, fault, illegal, retired
    );

    modport slave (
        output instr, zero, mem_ready,
        input  ALUCtrl, selMux1, reg_sel, rd1, rd2, wr, mem_to_reg,
               mem_rd, mem_wr, ir_wr, pc_wr, pc_src, imm,
               halted, fault, illegal, retired
    );
endinterface

// File: rtl/multicycle_ctrl_alu_decode.sv
// Maps opcode+funct to the ALU control code and flags unsupported encodings.
// Purely combinational, zero latency, no flow control.
module alu_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] op,
    input  logic [2:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       legal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: legal    = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW, OP_HALT: alu_ctrl = ALU_ADD;
            OP_BEQ:  alu_ctrl = ALU_SUB;
            default: legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FSM sequencing fetch/decode/read/exec/mem/write-back for the 16-bit datapath.
// 4-5 cycles per instruction plus one per memory wait cycle; faults after WAIT_MAX stalled cycles.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic          clk,
    input  logic          reset,
    multicycle_ctrl_if.master bus
);

    state_t     state;
    state_t     state_n;
    instr_t     ir_q;
    logic [7:0] wait_cnt;
    logic [15:0] retired_q;
    logic       retire;
    logic       waiting;
    logic       timeout;
    logic       is_imm_op;
    logic [2:0] dec_alu;
    logic       dec_legal;

    alu_decode u_alu_decode (
        .op       (ir_q.op),
        .funct    (ir_q.funct),
        .alu_ctrl (dec_alu),
        .legal    (dec_legal)
    );

    // A ready in the same cycle as the limit always wins over the timeout.
    assign waiting   = ((state == S_FETCH) || (state == S_MEM)) && !bus.mem_ready;
    assign timeout   = waiting && (({1'b0, wait_cnt} + 9'd1) >= 9'(WAIT_MAX));
    assign is_imm_op = (ir_q.op == OP_ADDI) || (ir_q.op == OP_LW) || (ir_q.op == OP_SW);

    assign bus.imm     = sext6(ir_q[5:0]);
    assign bus.retired = retired_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_FETCH;
            ir_q      <= '0;
            wait_cnt  <= '0;
            retired_q <= '0;
        end else begin
            state <= state_n;
            if ((state == S_FETCH) && bus.mem_ready) begin
                ir_q <= instr_t'(bus.instr);
            end
            if (state_n != state) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (retire) begin
                retired_q <= retired_q + 16'd1;
            end
        end
    end

    // Outputs are held low while reset is asserted so every strobe drops asynchronously.
    always_comb begin
        state_n        = state;
        retire         = 1'b0;
        bus.ALUCtrl    = '0;
        bus.selMux1    = 1'b0;
        bus.reg_sel    = '0;
        bus.rd1        = 1'b0;
        bus.rd2        = 1'b0;
        bus.wr         = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.ir_wr      = 1'b0;
        bus.pc_wr      = 1'b0;
        bus.pc_src     = 1'b0;
        bus.halted     = 1'b0;
        bus.fault      = 1'b0;
        bus.illegal    = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    bus.mem_rd = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_wr = 1'b1;
                        bus.pc_wr = 1'b1;
                        state_n   = S_DECODE;
                    end else if (timeout) begin
                        state_n = S_FAULT;
                    end
                end
                S_DECODE: begin
                    bus.reg_sel = ir_q.rs;
                    bus.rd1     = 1'b1;
                    if (!dec_legal) begin
                        bus.illegal = 1'b1;
                        state_n     = S_FETCH;
                    end else begin
                        case (ir_q.op)
                            OP_RTYPE, OP_SW, OP_BEQ: state_n = S_READ2;
                            OP_ADDI, OP_LW:          state_n = S_EXEC;
                            OP_HALT:                 state_n = S_HALT;
                            default:                 state_n = S_FETCH;
                        endcase
                    end
                end
                S_READ2: begin
                    bus.reg_sel = ir_q.rt;
                    bus.rd2     = 1'b1;
                    state_n     = S_EXEC;
                end
                S_EXEC: begin
                    bus.ALUCtrl = dec_alu;
                    bus.selMux1 = is_imm_op;
                    case (ir_q.op)
                        OP_LW, OP_SW: state_n = S_MEM;
                        OP_BEQ: begin
                            bus.pc_wr  = bus.zero;
                            bus.pc_src = bus.zero;
                            retire     = 1'b1;
                            state_n    = S_FETCH;
                        end
                        default: state_n = S_WB;
                    endcase
                end
                S_MEM: begin
                    bus.ALUCtrl = dec_alu;
                    bus.selMux1 = is_imm_op;
                    bus.mem_rd  = (ir_q.op == OP_LW);
                    bus.mem_wr  = (ir_q.op == OP_SW);
                    if (bus.mem_ready) begin
                        if (ir_q.op == OP_LW) begin
                            state_n = S_WB;
                        end else begin
                            retire  = 1'b1;
                            state_n = S_FETCH;
                        end
                    end else if (timeout) begin
                        state_n = S_FAULT;
                    end
                end
                S_WB: begin
                    bus.reg_sel    = ir_q.rd;
                    bus.wr         = 1'b1;
                    bus.mem_to_reg = (ir_q.op == OP_LW);
                    retire         = 1'b1;
                    state_n        = S_FETCH;
                end
                S_HALT:  bus.halted = 1'b1;
                S_FAULT: bus.fault  = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed plus randomized bench for multicycle_ctrl against a per-instruction trace model.
module tb_multicycle_ctrl;

    localparam int WMAX = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.WAIT_MAX(WMAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic mem_rd, mem_wr, ir_wr, pc_wr, pc_src, rd1, rd2, wr, mem_to_reg;
        logic sel_mux1, illegal, halted, fault;
        logic [2:0] reg_sel;
        logic [2:0] alu;
        logic [15:0] imm;
    } obs_t;

    obs_t obs;
    assign obs = {bus.mem_rd, bus.mem_wr, bus.ir_wr, bus.pc_wr, bus.pc_src, bus.rd1, bus.rd2,
                  bus.wr, bus.mem_to_reg, bus.selMux1, bus.illegal, bus.halted, bus.fault,
                  bus.reg_sel, bus.ALUCtrl, bus.imm};

    int n_cmp = 0;
    int n_bad = 0;
    obs_t exp_q[$];
    logic rdy_q[$];
    logic [15:0] ret_m;
    logic [15:0] ir_m;
    logic [2:0]  r_alu [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    logic [3:0]  rnd_ops [10] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'hA, 4'h0, 4'h2};

    function automatic logic [15:0] sext(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

    function automatic obs_t idle();
        obs_t o = '0;
        o.imm = sext(ir_m[5:0]);
        return o;
    endfunction

    task automatic chk_obs(input string tag, input obs_t e);
        n_cmp++;
        assert (obs === e) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] e);
        n_cmp++;
        assert (got === e) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, e);
        end
    endtask

    // Expected per-cycle outputs for one instruction, from the instruction's phase list.
    task automatic build(input logic [15:0] i, input int fw, input int mw, input logic z);
        obs_t o;
        logic [3:0] op = i[15:12];
        logic [2:0] f = i[2:0];
        logic legal = (op == 4'h0) ? (f <= 3'd4) : (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'hF});
        logic [2:0] alu = (op == 4'h0) ? r_alu[(f <= 3'd4) ? f : 3'd0]
                                       : ((op == 4'h4) ? 3'b110 : 3'b010);
        for (int k = 0; k <= fw; k++) begin
            o = idle();
            o.mem_rd = 1'b1;
            if (k == fw) begin
                o.ir_wr = 1'b1;
                o.pc_wr = 1'b1;
            end
            exp_q.push_back(o);
            rdy_q.push_back(k == fw);
        end
        ir_m = i;
        o = idle();
        o.rd1 = 1'b1;
        o.reg_sel = i[8:6];
        o.illegal = !legal;
        exp_q.push_back(o);
        rdy_q.push_back(1'($urandom));
        if (!legal || op == 4'hF) return;
        if (op inside {4'h0, 4'h3, 4'h4}) begin
            o = idle();
            o.rd2 = 1'b1;
            o.reg_sel = i[5:3];
            exp_q.push_back(o);
            rdy_q.push_back(1'($urandom));
        end
        o = idle();
        o.alu = alu;
        o.sel_mux1 = (op inside {4'h1, 4'h2, 4'h3});
        o.pc_wr = (op == 4'h4) && z;
        o.pc_src = (op == 4'h4) && z;
        exp_q.push_back(o);
        rdy_q.push_back(1'($urandom));
        if (op == 4'h4) begin
            ret_m = ret_m + 16'd1;
            return;
        end
        if (op == 4'h2 || op == 4'h3) begin
            for (int k = 0; k <= mw; k++) begin
                o = idle();
                o.mem_rd = (op == 4'h2);
                o.mem_wr = (op == 4'h3);
                o.alu = 3'b010;
                o.sel_mux1 = 1'b1;
                exp_q.push_back(o);
                rdy_q.push_back(k == mw);
            end
            if (op == 4'h3) begin
                ret_m = ret_m + 16'd1;
                return;
            end
        end
        o = idle();
        o.wr = 1'b1;
        o.reg_sel = i[11:9];
        o.mem_to_reg = (op == 4'h2);
        exp_q.push_back(o);
        rdy_q.push_back(1'($urandom));
        ret_m = ret_m + 16'd1;
    endtask

    task automatic play(input logic [15:0] i, input logic z, input string tag, input int limit);
        obs_t e;
        logic r;
        int n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            @(negedge clk);
            r = rdy_q.pop_front();
            e = exp_q.pop_front();
            bus.mem_ready = r;
            bus.instr = r ? i : 16'($urandom);
            bus.zero = z;
            #1 chk_obs(tag, e);
            n++;
        end
    endtask

    task automatic run(input logic [15:0] i, input int fw, input int mw, input logic z,
                       input string tag);
        build(i, fw, mw, z);
        play(i, z, tag, 1000);
        @(posedge clk);
        #1 chk16({tag, "_retired"}, bus.retired, ret_m);
    endtask

    task automatic do_reset();
        obs_t o;
        @(negedge clk);
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        ret_m = '0;
        ir_m = '0;
        #1 chk_obs("reset_outputs", '0);
        chk16("reset_retired", bus.retired, 16'h0000);
        @(posedge clk);
        #2 reset = 1'b0;
        o = '0;
        o.mem_rd = 1'b1;
        #1 chk_obs("post_reset", o);
    endtask

    initial begin
        obs_t o;
        logic [15:0] ri;
        reset = 1'b1;
        bus.instr = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        ret_m = '0;
        ir_m = '0;

        do_reset();
        run(16'h0A98, 0, 0, 1'b0, "rtype_add");
        run(16'h2A85, 0, 3, 1'b0, "lw_wait3");
        run(16'h4A98, 0, 0, 1'b1, "beq_taken");
        run(16'h4A98, 0, 0, 1'b0, "beq_not_taken");
        run(16'h7123, 0, 0, 1'b0, "illegal_op7");
        run(16'h0A9D, 0, 0, 1'b0, "illegal_funct5");
        run(16'h1A7F, 3, 0, 1'b0, "ready_on_limit");

        for (int n = 0; n < 40; n++) begin
            ri = 16'($urandom);
            ri[15:12] = rnd_ops[$urandom_range(0, 9)];
            run(ri, $urandom_range(0, WMAX - 1), $urandom_range(0, WMAX - 1), 1'($urandom), "random");
        end

        force dut.retired_q = 16'hFFFF;
        #1 release dut.retired_q;
        ret_m = 16'hFFFF;
        chk16("retired_forced", bus.retired, 16'hFFFF);
        run(16'h1245, 0, 0, 1'b0, "retired_wrap");

        for (int k = 0; k < WMAX; k++) begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            o = idle();
            o.mem_rd = 1'b1;
            #1 chk_obs("fetch_stall", o);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.mem_ready = 1'(k);
            o = idle();
            o.fault = 1'b1;
            #1 chk_obs("fault_state", o);
        end

        do_reset();
        run(16'hF000, 0, 0, 1'b0, "halt");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.mem_ready = 1'($urandom);
            o = idle();
            o.halted = 1'b1;
            #1 chk_obs("halt_state", o);
        end

        do_reset();
        build(16'h3A85, 0, 3, 1'b0);
        play(16'h3A85, 1'b0, "sw_before_reset", 5);
        exp_q.delete();
        rdy_q.delete();
        @(posedge clk);
        #2 reset = 1'b1;
        ret_m = '0;
        ir_m = '0;
        #1 chk_obs("reset_mid_mem", '0);
        chk16("reset_mid_mem_retired", bus.retired, 16'h0000);
        @(posedge clk);
        #2 reset = 1'b0;
        o = '0;
        o.mem_rd = 1'b1;
        #1 chk_obs("post_reset_mid_mem", o);
        run(16'h1245, 0, 0, 1'b0, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
